// File: rtl/game_pkg.sv
// Shared state/mode codes and default option constants for the typing-race sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    COUNTDOWN = 2'd1,
    INGAME    = 2'd2,
    FINISH    = 2'd3
  } state_e;

  localparam logic MODE_TIME = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  localparam int unsigned TIME_STEP_DEF = 15;
  localparam int unsigned TIME_CNT_DEF  = 6;
  localparam int unsigned WORD_STEP_DEF = 25;
  localparam int unsigned WORD_CNT_DEF  = 4;
  localparam int unsigned CD_SECS_DEF   = 3;

endpackage

// File: rtl/game_if.sv
// Button/tick inputs and display/score outputs of the game sequencer.
interface game_if #(
  parameter int unsigned VAL_W = 7,
  parameter int unsigned VOL_W = 5,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             sel_up;
  logic             sel_down;
  logic             vol_up;
  logic             vol_down;
  logic             mode;
  logic             tick_1s;
  logic             word_done;
  logic [1:0]       state;
  logic             mode_q;
  logic [VAL_W-1:0] sel_value;
  logic [VAL_W-1:0] remain;
  logic [1:0]       cd;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] words;
  logic [VOL_W-1:0] vol;
  logic             finish;

  modport master (
    output start, abort, sel_up, sel_down, vol_up, vol_down, mode, tick_1s, word_done,
    input  state, mode_q, sel_value, remain, cd, elapsed, words, vol, finish
  );

  modport slave (
    input  start, abort, sel_up, sel_down, vol_up, vol_down, mode, tick_1s, word_done,
    output state, mode_q, sel_value, remain, cd, elapsed, words, vol, finish
  );
endinterface

// File: rtl/game_ctrl_step_selector.sv
// Target selector stepping through STEP..STEP*CNT with wrap-around in both directions.
module step_selector #(
  parameter int unsigned W    = 7,
  parameter int unsigned STEP = 15,
  parameter int unsigned CNT  = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] val
);
  localparam logic [W-1:0] STEP_V = W'(STEP);
  localparam logic [W-1:0] MAX_V  = W'(STEP * CNT);

  logic [W-1:0] r_val;
  logic [W-1:0] w_val;

  always_comb begin
    w_val = r_val;
    if (en && up && !down) begin
      w_val = (r_val == MAX_V) ? STEP_V : r_val + STEP_V;
    end else if (en && down && !up) begin
      w_val = (r_val == STEP_V) ? MAX_V : r_val - STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_val <= STEP_V;
    else     r_val <= w_val;
  end

  assign val = r_val;
endmodule

// File: rtl/game_ctrl.sv
// Typing-race game sequencer: target selection, countdown, in-game tracking, volume.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned VAL_W     = 7,
  parameter int unsigned TIME_STEP = TIME_STEP_DEF,
  parameter int unsigned TIME_CNT  = TIME_CNT_DEF,
  parameter int unsigned WORD_STEP = WORD_STEP_DEF,
  parameter int unsigned WORD_CNT  = WORD_CNT_DEF,
  parameter int unsigned CD_SECS   = CD_SECS_DEF,
  parameter int unsigned VOL_W     = 5,
  parameter int unsigned VOL_MAX   = 16,
  parameter int unsigned VOL_INIT  = 8,
  parameter int unsigned CNT_W     = 8
) (
  input logic   clk,
  input logic   rst,
  game_if.slave bus
);
  state_e           r_state, w_state;
  logic             r_mode, w_mode;
  logic [VAL_W-1:0] r_remain, w_remain;
  logic [1:0]       r_cd, w_cd;
  logic [CNT_W-1:0] r_elapsed, w_elapsed;
  logic [CNT_W-1:0] r_words, w_words;
  logic [VOL_W-1:0] r_vol, w_vol;
  logic             r_finish, w_finish;

  logic [VAL_W-1:0] w_time_sel, w_word_sel, w_sel_value;
  logic             w_sel_en, w_evt;

  // Steps are frozen on the start cycle so the latched target matches what was shown.
  assign w_sel_en = (r_state == SELECT) && !bus.start;

  step_selector #(.W(VAL_W), .STEP(TIME_STEP), .CNT(TIME_CNT)) u_time_sel (
    .clk  (clk),
    .rst  (rst),
    .en   (w_sel_en && (r_mode == MODE_TIME)),
    .up   (bus.sel_up),
    .down (bus.sel_down),
    .val  (w_time_sel)
  );

  step_selector #(.W(VAL_W), .STEP(WORD_STEP), .CNT(WORD_CNT)) u_word_sel (
    .clk  (clk),
    .rst  (rst),
    .en   (w_sel_en && (r_mode == MODE_WORD)),
    .up   (bus.sel_up),
    .down (bus.sel_down),
    .val  (w_word_sel)
  );

  assign w_sel_value = (r_mode == MODE_WORD) ? w_word_sel : w_time_sel;
  assign w_evt       = (r_mode == MODE_WORD) ? bus.word_done : bus.tick_1s;

  always_comb begin
    w_state   = r_state;
    w_mode    = r_mode;
    w_remain  = r_remain;
    w_cd      = r_cd;
    w_elapsed = r_elapsed;
    w_words   = r_words;
    w_finish  = 1'b0;
    unique case (r_state)
      SELECT: begin
        w_mode = bus.mode;
        if (bus.start) begin
          w_state   = COUNTDOWN;
          w_cd      = 2'(CD_SECS);
          w_remain  = w_sel_value;
          w_elapsed = '0;
          w_words   = '0;
        end
      end
      COUNTDOWN: begin
        if (bus.abort) begin
          w_state  = SELECT;
          w_remain = '0;
          w_cd     = '0;
        end else if (bus.tick_1s) begin
          w_cd = r_cd - 2'd1;
          if (r_cd == 2'd1) w_state = INGAME;
        end
      end
      INGAME: begin
        if (bus.abort) begin
          w_state  = SELECT;
          w_remain = '0;
          w_cd     = '0;
        end else begin
          if (bus.tick_1s && (r_elapsed != '1)) w_elapsed = r_elapsed + 1'b1;
          if (bus.word_done && (r_words != '1)) w_words = r_words + 1'b1;
          if (w_evt && (r_remain != '0)) begin
            w_remain = r_remain - 1'b1;
            if (r_remain == VAL_W'(1)) begin
              w_state  = FINISH;
              w_finish = 1'b1;
            end
          end
        end
      end
      FINISH: begin
        if (bus.start) w_state = SELECT;
      end
    endcase
  end

  always_comb begin
    w_vol = r_vol;
    if (bus.vol_up && !bus.vol_down && (r_vol < VOL_W'(VOL_MAX))) w_vol = r_vol + 1'b1;
    else if (bus.vol_down && !bus.vol_up && (r_vol != '0))      w_vol = r_vol - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SELECT;
      r_mode    <= MODE_TIME;
      r_remain  <= '0;
      r_cd      <= '0;
      r_elapsed <= '0;
      r_words   <= '0;
      r_vol     <= VOL_W'(VOL_INIT);
      r_finish  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mode    <= w_mode;
      r_remain  <= w_remain;
      r_cd      <= w_cd;
      r_elapsed <= w_elapsed;
      r_words   <= w_words;
      r_vol     <= w_vol;
      r_finish  <= w_finish;
    end
  end

  assign bus.state     = r_state;
  assign bus.mode_q    = r_mode;
  assign bus.sel_value = w_sel_value;
  assign bus.remain    = r_remain;
  assign bus.cd        = r_cd;
  assign bus.elapsed   = r_elapsed;
  assign bus.words     = r_words;
  assign bus.vol       = r_vol;
  assign bus.finish    = r_finish;
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the typing-race game. It replaces the fixed 3-state selector.
- Holds the mode (time-limited or word-count), the per-mode target chosen with wrap-around up/down stepping, and the volume.
- Runs a pre-game countdown, tracks remaining seconds or words during play, and raises a one-cycle finish pulse.
- Sits between the debounced/one-pulsed buttons and the display, sound and scoring blocks.

Parameters:
- VAL_W, 7: width of target/remaining values. Must hold TIME_STEP*TIME_CNT and WORD_STEP*WORD_CNT.
- TIME_STEP, 15: time-mode option step, in seconds.
- TIME_CNT, 6: number of time options (15..90).
- WORD_STEP, 25: word-mode option step, in words.
- WORD_CNT, 4: number of word options (25..100).
- CD_SECS, 3: length of the pre-game countdown, in seconds.
- VOL_W, 5: volume width.
- VOL_MAX, 16: volume ceiling.
- VOL_INIT, 8: volume after reset.
- CNT_W, 8: width of the elapsed-seconds and words-typed counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse (BtnC)
- abort  in  1  one-cycle pulse; abandon the current game
- sel_up  in  1  one-cycle pulse
- sel_down  in  1  one-cycle pulse
- vol_up  in  1  one-cycle pulse
- vol_down  in  1  one-cycle pulse
- mode  in  1  switch; 0 = time mode, 1 = word mode
- tick_1s  in  1  one-cycle pulse, once per second
- word_done  in  1  one-cycle pulse per correctly completed word
- state  out  2  current state code
- mode_q  out  1  latched mode
- sel_value  out  VAL_W  target selected for mode_q
- remain  out  VAL_W  seconds or words left
- cd  out  2  countdown digit
- elapsed  out  CNT_W  seconds played
- words  out  CNT_W  words typed
- vol  out  VOL_W  volume
- finish  out  1  one-cycle pulse on entering FINISH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All state is registered; outputs come straight from registers.
- Reset values:
  - state=SELECT, mode_q=0
  - time_sel=TIME_STEP, word_sel=WORD_STEP
  - remain=0, cd=0, elapsed=0, words=0
  - vol=VOL_INIT, finish=0
- Reset mid-game returns everything to these values immediately; no game state survives.
- States: SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- SELECT:
  - mode_q follows mode every cycle.
  - sel_up/sel_down step the target of the current mode by its STEP.
  - Wrap-around: max + up gives STEP; STEP + down gives max.
  - up and down in the same cycle: no change.
  - The other mode's target is untouched.
  - sel_value = mode_q ? word_sel : time_sel.
- SELECT, start:
  - Next cycle: state=COUNTDOWN, cd=CD_SECS, remain=sel_value, elapsed=0, words=0.
  - A step pulse in the same cycle as start is ignored.
- COUNTDOWN:
  - Each tick_1s decrements cd.
  - A tick while cd==1 gives cd=0 and state=INGAME.
  - start, sel_* and word_done are ignored.
- INGAME:
  - tick_1s: elapsed increments, saturating at all-ones.
  - word_done: words increments, saturating.
  - Time mode: tick_1s decrements remain. Word mode: word_done decrements remain.
  - The decrement that takes remain from 1 to 0 moves the state to FINISH and raises finish high for exactly that one cycle.
  - tick_1s and word_done in the same cycle: both counters update; only the mode-relevant event touches remain.
- abort in COUNTDOWN or INGAME:
  - Next cycle: state=SELECT, remain=0, cd=0, no finish pulse.
  - Selections and the elapsed/words counters are retained.
  - abort has priority over every other event; it is ignored in SELECT and FINISH.
- FINISH:
  - remain, elapsed and words are frozen for score display.
  - start returns to SELECT; the counters hold until the next start.
- Volume (any state):
  - vol_up saturates at VOL_MAX; vol_down saturates at 0.
  - Both in the same cycle: no change.
- State code 2'b11 is FINISH. No illegal codes exist.

Decomposition:
- Package game_pkg:
  - state codes SELECT/COUNTDOWN/INGAME/FINISH
  - mode codes MODE_TIME=0, MODE_WORD=1
  - default step/count constants
- Sub-module step_selector:
  - Parameters W, STEP, CNT.
  - Inputs en, up, down; output val.
  - Wrap-around stepping as defined above, reset value STEP.
  - Instantiated twice, for time_sel and word_sel, each enabled only in SELECT with matching mode.

Test Plan:
- Reset, mode=0, five sel_up pulses: sel_value 15→30→45→60→75→90. Sixth sel_up → 15. One sel_down from 15 → 90.
- mode=1, sel_down once: sel_value=100, and time_sel still holds its prior value. sel_up and sel_down together: no change.
- Time mode, target 15, start, 3 ticks: cd 3→2→1→0, state=INGAME, remain=15. 15 further ticks: remain reaches 0, state=FINISH, finish high one cycle, elapsed=15.
- Word mode, target 25, 25 word_done pulses interleaved with 7 ticks: state=FINISH on the 25th pulse, words=25, elapsed=7. Ticks do not change remain.
- INGAME, abort on the same cycle as the final word_done: state=SELECT, no finish pulse, remain=0.
- 20 vol_up pulses: vol=16. 20 vol_down pulses: vol=0. rst asserted mid-INGAME: all outputs at reset values immediately.
